fetch_queue_stage: RTL and testbench

//  Instruction fetch stage feeding the control unit / register file / immediate-extend datapath.
//  - Owns the PC and drives the instruction ROM address; the ROM read is combinational.
//  - Buffers {pc, instr} pairs in a small circular prefetch queue and hands them downstream

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue_stage.sv | 96 +++++++++
 tb/tb_fetch_queue_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// XLEN sets the datapath width; PC_STEP is the byte distance between instructions.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               pushEntry,
    output fetch_entry_t               headEntry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t entries [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;

    // Flush and reset both discard the contents; stale entries are never read
    // because visibility is governed purely by count.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // When full, a simultaneous push lands in the slot being consumed this edge.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tailPtr] <= pushEntry;
        end
    end

    assign headEntry = entries[headPtr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC register, ROM addressing, prefetch queue and redirect handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       fetchEnable,
    output logic [31:0]                romAddress,
    input  logic [31:0]                romData,
    input  logic                       redirectValid,
    input  logic [31:0]                redirectAddress,
    input  logic                       outReady,
    output logic                       outValid,
    output logic [31:0]                outInstr,
    output logic [31:0]                outPC,
    output logic [$clog2(DEPTH+1)-1:0] queueCount,
    output logic [31:0]                perfFetched,
    output logic [31:0]                perfStalls
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0] pcReg;
    logic            push;
    logic            pop;
    fetch_entry_t    pushEntry;
    fetch_entry_t    headEntry;
    logic            unusedRedirectBits;

    assign unusedRedirectBits = ^redirectAddress[1:0];

    assign romAddress = pcReg;
    assign outValid   = (queueCount != '0);
    assign pop        = outValid & outReady;
    assign push       = fetchEnable & ~redirectValid & ((queueCount < CNT_W'(DEPTH)) | pop);
    assign pushEntry  = '{pc: pcReg, instr: romData};

    assign outInstr = outValid ? headEntry.instr : NOP_INSTR;
    assign outPC    = outValid ? headEntry.pc    : 32'h0;

    // PC only advances when the fetched word is actually captured by the queue.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pcReg <= RESET_PC;
        end else if (redirectValid) begin
            pcReg <= {redirectAddress[31:2], 2'b00};
        end else if (push) begin
            pcReg <= next_pc(pcReg);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .reset     (Reset),
        .flush     (redirectValid),
        .push      (push),
        .pop       (pop),
        .pushEntry (pushEntry),
        .headEntry (headEntry),
        .count     (queueCount)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchedCnt;
    logic [31:0] stallCnt;

    // Counters survive redirects so they reflect the whole run since reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetchedCnt <= '0;
            stallCnt   <= '0;
        end else begin
            if (push) begin
                fetchedCnt <= fetchedCnt + 32'd1;
            end
            if (outValid && !outReady) begin
                stallCnt <= stallCnt + 32'd1;
            end
        end
    end

    assign perfFetched = fetchedCnt;
    assign perfStalls  = stallCnt;
`else
    assign perfFetched = 32'h0;
    assign perfStalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: scoreboard of {pc, instr} pairs plus directed checks.
module tb_fetch_queue_stage;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic          CLK;
    logic          Reset;
    logic          fetchEnable;
    logic [31:0]   romAddress;
    logic [31:0]   romData;
    logic          redirectValid;
    logic [31:0]   redirectAddress;
    logic          outReady;
    logic          outValid;
    logic [31:0]   outInstr;
    logic [31:0]   outPC;
    logic [CW-1:0] queueCount;
    logic [31:0]   perfFetched;
    logic [31:0]   perfStalls;

    int total = 0;
    int bad   = 0;

    logic [63:0] scoreboard[$];
    logic [31:0] expPc;
    logic [31:0] expFetched;
    logic [31:0] expStalls;
    bit          modelKnown = 0;

    fetch_queue_stage #(
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .fetchEnable     (fetchEnable),
        .romAddress      (romAddress),
        .romData         (romData),
        .redirectValid   (redirectValid),
        .redirectAddress (redirectAddress),
        .outReady        (outReady),
        .outValid        (outValid),
        .outInstr        (outInstr),
        .outPC           (outPC),
        .queueCount      (queueCount),
        .perfFetched     (perfFetched),
        .perfStalls      (perfStalls)
    );

    // ROM holds its own word index: ROM[i] = i.
    assign romData = {2'b00, romAddress[31:2]};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] head;
        if (!modelKnown) return;
        head = (scoreboard.size() != 0) ? scoreboard[0] : 64'h0;
        check32("romAddress", romAddress, expPc);
        check32("outValid", {31'b0, outValid}, {31'b0, scoreboard.size() != 0});
        check32("queueCount", 32'(queueCount), 32'(scoreboard.size()));
        check32("outPC", outPC, head[63:32]);
        check32("outInstr", outInstr, head[31:0]);
`ifdef FETCH_PERF_CNT_EN
        check32("perfFetched", perfFetched, expFetched);
        check32("perfStalls", perfStalls, expStalls);
`else
        check32("perfFetched", perfFetched, 32'h0);
        check32("perfStalls", perfStalls, 32'h0);
`endif
    endtask

    // Drives one cycle of inputs, checks the current outputs, then advances the model across the edge.
    task automatic applyStimulus(input logic fe, input logic rdy, input logic rv,
                                 input logic [31:0] ra, input logic rst);
        bit mPop;
        bit mPush;
        fetchEnable     = fe;
        outReady        = rdy;
        redirectValid   = rv;
        redirectAddress = ra;
        Reset           = rst;
        checkOutput();
        mPop  = (scoreboard.size() != 0) && rdy;
        mPush = fe && !rv && ((scoreboard.size() < DEPTH) || mPop);
        if (rst) begin
            scoreboard.delete();
            expPc      = 32'h0;
            expFetched = 32'h0;
            expStalls  = 32'h0;
        end else begin
            if (scoreboard.size() != 0 && !rdy) expStalls = expStalls + 32'd1;
            if (rv) begin
                scoreboard.delete();
                expPc = {ra[31:2], 2'b00};
            end else begin
                if (mPop) void'(scoreboard.pop_front());
                if (mPush) begin
                    scoreboard.push_back({expPc, 2'b00, expPc[31:2]});
                    expPc      = expPc + 32'd4;
                    expFetched = expFetched + 32'd1;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        if (rst) modelKnown = 1;
    endtask

    initial begin
        fetchEnable     = 1'b0;
        outReady        = 1'b0;
        redirectValid   = 1'b0;
        redirectAddress = 32'h0;
        Reset           = 1'b1;
        @(negedge CLK);
        applyStimulus(0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);

        $display("[TB] streaming fetch with outReady=1");
        applyStimulus(1, 1, 0, 32'h0, 0);
        check32("stream_rom1", romAddress, 32'h4);
        check32("stream_valid1", {31'b0, outValid}, 32'h1);
        check32("stream_pc0", outPC, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 32'h0, 0);
        check32("stream_pc6", outPC, 32'h18);
        check32("stream_instr6", outInstr, 32'h6);

        $display("[TB] fill with outReady=0");
        applyStimulus(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'h0, 0);
        check32("full_count", 32'(queueCount), 32'd2);
        check32("full_rom", romAddress, 32'h8);
        check32("full_pc", outPC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check32("full_stalls", perfStalls, 32'd3);
`endif

        $display("[TB] single-cycle pop at full");
        applyStimulus(1, 1, 0, 32'h0, 0);
        check32("pulse_count", 32'(queueCount), 32'd2);
        check32("pulse_rom", romAddress, 32'hC);
        check32("pulse_pc", outPC, 32'h4);

        $display("[TB] redirect while full");
        applyStimulus(1, 0, 1, 32'h0000_0103, 0);
        check32("redir_valid", {31'b0, outValid}, 32'h0);
        check32("redir_count", 32'(queueCount), 32'd0);
        check32("redir_rom", romAddress, 32'h100);
        applyStimulus(1, 0, 0, 32'h0, 0);
        check32("redir_pc", outPC, 32'h100);
        check32("redir_instr", outInstr, 32'h40);

        $display("[TB] drain with fetchEnable=0");
        applyStimulus(0, 1, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0, 0);
        check32("drain_valid", {31'b0, outValid}, 32'h0);
        check32("drain_rom", romAddress, 32'h104);

        $display("[TB] PC wrap");
        applyStimulus(1, 0, 1, 32'hFFFF_FFFE, 0);
        check32("wrap_rom_pre", romAddress, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 32'h0, 0);
        check32("wrap_rom", romAddress, 32'h0);
        check32("wrap_pc", outPC, 32'hFFFF_FFFC);
        check32("wrap_count", 32'(queueCount), 32'd1);

        $display("[TB] reset with pending redirect");
        applyStimulus(1, 1, 1, 32'h0000_0200, 1);
        check32("rst_valid", {31'b0, outValid}, 32'h0);
        check32("rst_rom", romAddress, 32'h0);
        check32("rst_fetched", perfFetched, 32'h0);
        check32("rst_stalls", perfStalls, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                          ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 49) == 0));
        end
        applyStimulus(0, 1, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
